// File: rtl/posit_pkg.sv
// Shared posit types: formats, min/max selection, non-computational op codes.
package posit_pkg;

  typedef enum logic [1:0] {
    POSIT32 = 2'd0,
    POSIT16 = 2'd1,
    POSIT8  = 2'd2
  } posit_format_e;

  typedef enum logic {
    MIN = 1'b0,
    MAX = 1'b1
  } roundmode_e;

  typedef enum logic {
    MINMAX = 1'b0
  } operation_e;

  // NaR is the lone pattern with only the sign bit set; narrower formats take the top bits.
  localparam logic [31:0] POSIT_NAR = 32'h8000_0000;

  function automatic int unsigned posit_width(posit_format_e fmt);
    case (fmt)
      POSIT16: return 16;
      POSIT8:  return 8;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/posit_noncomp.sv
// Posit min/max unit; NaR acts as identity, otherwise posits order as signed integers.
// REG_OUT=0 gives a zero-latency pass-through, REG_OUT=1 a one-entry output register.
module posit_noncomp
  import posit_pkg::*;
#(
  parameter posit_format_e pFormat = posit_format_e'(0),
  parameter bit            REG_OUT = 1'b0,
  localparam int           WIDTH   = posit_width(pFormat)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0][WIDTH-1:0] operands_i,
  input  roundmode_e            rnd_mode_i,
  input  operation_e            op_i,
  input  logic                  op_mod_i,
  input  logic                  tag_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [WIDTH-1:0]      result_o,
  output logic                  tag_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam logic [WIDTH-1:0] NAR = POSIT_NAR[31 -: WIDTH];

  logic [WIDTH-1:0] a, b, mm;
  logic             a_lt_b;
  logic             full_q, tag_q;
  logic [WIDTH-1:0] res_q;
  logic             acc_in;
  logic             unused_op;

  assign a         = operands_i[0];
  assign b         = operands_i[1];
  assign a_lt_b    = $signed(a) < $signed(b);
  assign unused_op = ^{op_i, op_mod_i};

  always_comb begin
    mm = a;
    if (a == NAR)              mm = b;
    else if (b == NAR)         mm = a;
    else if (rnd_mode_i == MAX) mm = a_lt_b ? b : a;
    else                       mm = a_lt_b ? a : b;
  end

  assign in_ready_o  = REG_OUT ? (!full_q || out_ready_i) : out_ready_i;
  assign acc_in      = in_valid_i && in_ready_o;
  assign out_valid_o = REG_OUT ? full_q : in_valid_i;
  assign result_o    = REG_OUT ? res_q  : mm;
  assign tag_o       = REG_OUT ? tag_q  : tag_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      res_q  <= '0;
      tag_q  <= 1'b0;
    end else if (acc_in) begin
      full_q <= 1'b1;
      res_q  <= mm;
      tag_q  <= tag_i;
    end else if (out_ready_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/posit_minmax_reducer.sv
// Folds a stream of posits into one min or max by issuing pairwise requests
// to an external non-computational unit and accumulating its results.
module posit_minmax_reducer
  import posit_pkg::*;
#(
  parameter posit_format_e pFormat = posit_format_e'(0),
  parameter int            MaxLen  = 16,
  localparam int           WIDTH   = posit_width(pFormat),
  localparam int           LW      = $clog2(MaxLen + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  start_i,
  input  roundmode_e            mode_i,
  input  logic [LW-1:0]         len_i,
  input  logic [WIDTH-1:0]      elem_i,
  input  logic                  elem_valid_i,
  output logic                  elem_ready_o,
  output logic [1:0][WIDTH-1:0] nc_operands_o,
  output roundmode_e            nc_rnd_mode_o,
  output operation_e            nc_op_o,
  output logic                  nc_op_mod_o,
  output logic                  nc_tag_o,
  output logic                  nc_in_valid_o,
  input  logic                  nc_in_ready_i,
  input  logic [WIDTH-1:0]      nc_result_i,
  input  logic                  nc_tag_i,
  input  logic                  nc_out_valid_i,
  output logic                  nc_out_ready_o,
  output logic [WIDTH-1:0]      res_o,
  output logic                  res_err_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, opb_q, opb_d;
  logic [LW-1:0]    cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic             err_q, err_d;
  roundmode_e       mode_q, mode_d;
  logic             do_rsp;

  assign cnt_inc       = cnt_q + LW'(1);
  assign nc_rnd_mode_o = mode_q;
  assign nc_op_o       = MINMAX;
  assign nc_op_mod_o   = 1'b0;
  assign res_o         = acc_q;
  assign res_err_o     = err_q;
  assign busy_o        = (state_q != S_IDLE);

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    opb_d          = opb_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    err_d          = err_q;
    mode_d         = mode_q;
    do_rsp         = 1'b0;
    elem_ready_o   = 1'b0;
    nc_in_valid_o  = 1'b0;
    nc_out_ready_o = 1'b0;
    res_valid_o    = 1'b0;
    nc_operands_o  = '0;
    nc_tag_o       = 1'b0;

    case (state_q)
      S_IDLE: if (start_i && len_i != '0 && len_i <= LW'(MaxLen)) begin
        mode_d  = mode_i;
        len_d   = len_i;
        err_d   = 1'b0;
        state_d = S_FIRST;
      end
      S_FIRST: begin
        elem_ready_o = 1'b1;
        if (elem_valid_i) begin
          acc_d   = elem_i;
          cnt_d   = LW'(1);
          state_d = (len_q == LW'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        elem_ready_o = 1'b1;
        if (elem_valid_i) begin
          opb_d   = elem_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        nc_in_valid_o    = 1'b1;
        nc_out_ready_o   = 1'b1;
        nc_operands_o[0] = acc_q;
        nc_operands_o[1] = opb_q;
        nc_tag_o         = cnt_q[0];
        // A response without our request having gone out is not ours; it is drained.
        if (nc_in_ready_i) begin
          if (nc_out_valid_i) do_rsp = 1'b1;
          else                state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        nc_out_ready_o = 1'b1;
        if (nc_out_valid_i) do_rsp = 1'b1;
      end
      S_DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_rsp) begin
      acc_d   = nc_result_i;
      cnt_d   = cnt_inc;
      if (nc_tag_i != cnt_q[0]) err_d = 1'b1;
      state_d = (cnt_inc == len_q) ? S_DONE : S_FETCH;
    end

    // Flush wins over everything; nc_out_ready_o stays up so an in-flight response is swallowed.
    if (flush_i) begin
      state_d       = S_IDLE;
      acc_d         = acc_q;
      opb_d         = opb_q;
      cnt_d         = cnt_q;
      len_d         = len_q;
      err_d         = err_q;
      mode_d        = mode_q;
      elem_ready_o  = 1'b0;
      nc_in_valid_o = 1'b0;
      res_valid_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      mode_q  <= MIN;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_posit_minmax_reducer.sv
// Bench for posit_minmax_reducer driving a zero-latency or registered posit_noncomp downstream.
module tb_posit_minmax_reducer;
  import posit_pkg::*;

  localparam posit_format_e FMT  = POSIT32;
  localparam int            W    = 32;
  localparam int            MAXL = 16;
  localparam int            LW   = $clog2(MAXL + 1);
  localparam logic [31:0]   NAR  = 32'h8000_0000;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic               flush_i = 1'b0, start_i = 1'b0;
  roundmode_e         mode_i = MIN;
  logic [LW-1:0]      len_i = '0;
  logic [W-1:0]       elem_i = '0;
  logic               elem_valid_i = 1'b0, elem_ready_o;
  logic [1:0][W-1:0]  nc_operands_o;
  roundmode_e         nc_rnd_mode_o;
  operation_e         nc_op_o;
  logic               nc_op_mod_o, nc_tag_o, nc_in_valid_o, nc_in_ready_i;
  logic [W-1:0]       nc_result_i;
  logic               nc_tag_i, nc_out_valid_i, nc_out_ready_o;
  logic [W-1:0]       res_o;
  logic               res_err_o, res_valid_o, res_ready_i = 1'b0, busy_o;

  // downstream selection and fault-injection knobs
  logic use_lat = 1'b0, stall = 1'b0, flip_en = 1'b0, rsp_clr = 1'b0;
  logic r0, r1, ov0, ov1, tg0, tg1;
  logic [W-1:0] rs0, rs1;
  int   rsp_cnt = 0, iv_cnt = 0;

  always #5 clk = ~clk;

  posit_minmax_reducer #(.pFormat(FMT), .MaxLen(MAXL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .start_i(start_i), .mode_i(mode_i),
    .len_i(len_i), .elem_i(elem_i), .elem_valid_i(elem_valid_i), .elem_ready_o(elem_ready_o),
    .nc_operands_o(nc_operands_o), .nc_rnd_mode_o(nc_rnd_mode_o), .nc_op_o(nc_op_o),
    .nc_op_mod_o(nc_op_mod_o), .nc_tag_o(nc_tag_o), .nc_in_valid_o(nc_in_valid_o),
    .nc_in_ready_i(nc_in_ready_i), .nc_result_i(nc_result_i), .nc_tag_i(nc_tag_i),
    .nc_out_valid_i(nc_out_valid_i), .nc_out_ready_o(nc_out_ready_o), .res_o(res_o),
    .res_err_o(res_err_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .busy_o(busy_o)
  );

  posit_noncomp #(.pFormat(FMT), .REG_OUT(1'b0)) u_nc0 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(nc_operands_o), .rnd_mode_i(nc_rnd_mode_o),
    .op_i(nc_op_o), .op_mod_i(nc_op_mod_o), .tag_i(nc_tag_o),
    .in_valid_i(nc_in_valid_o && !stall && !use_lat), .in_ready_o(r0),
    .result_o(rs0), .tag_o(tg0), .out_valid_o(ov0), .out_ready_i(nc_out_ready_o && !use_lat)
  );

  posit_noncomp #(.pFormat(FMT), .REG_OUT(1'b1)) u_nc1 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(nc_operands_o), .rnd_mode_i(nc_rnd_mode_o),
    .op_i(nc_op_o), .op_mod_i(nc_op_mod_o), .tag_i(nc_tag_o),
    .in_valid_i(nc_in_valid_o && !stall && use_lat), .in_ready_o(r1),
    .result_o(rs1), .tag_o(tg1), .out_valid_o(ov1), .out_ready_i(nc_out_ready_o && use_lat)
  );

  assign nc_in_ready_i  = !stall && (use_lat ? r1 : r0);
  assign nc_out_valid_i = use_lat ? ov1 : ov0;
  assign nc_result_i    = use_lat ? rs1 : rs0;
  assign nc_tag_i       = (use_lat ? tg1 : tg0) ^ (flip_en && rsp_cnt == 1);

  always @(posedge clk) begin
    if (rsp_clr) begin
      rsp_cnt <= 0;
      iv_cnt  <= 0;
    end else begin
      if (nc_out_valid_i && nc_out_ready_o) rsp_cnt <= rsp_cnt + 1;
      if (nc_in_valid_o) iv_cnt <= iv_cnt + 1;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: NaR carries no order, so pick the extreme of the remaining signed values.
  roundmode_e  t_mode;
  int          t_len, t_gap, t_stall, t_hold;
  logic [31:0] t_el[MAXL];
  logic [31:0] r_res;
  logic        r_err;
  int          r_lat;

  function automatic logic [31:0] model();
    bit have = 0;
    longint best = 0, v;
    for (int i = 0; i < t_len; i++) begin
      if (t_el[i] != NAR) begin
        v = longint'($signed(t_el[i]));
        if (!have || (t_mode == MAX ? v > best : v < best)) best = v;
        have = 1;
      end
    end
    return have ? best[31:0] : NAR;
  endfunction

  task automatic run_red();
    int k = 0, g = 0, sd = 0;
    logic cons, cap_tag;
    logic [1:0][W-1:0] cap_ops;
    @(negedge clk);
    rsp_clr = 1'b1; start_i = 1'b1; mode_i = t_mode; len_i = LW'(t_len);
    @(posedge clk); r_lat = 1;
    @(negedge clk);
    rsp_clr = 1'b0; start_i = 1'b0;
    while (!res_valid_o && g < 3000) begin
      if (k < t_len && int'($urandom_range(99)) >= t_gap) begin
        elem_valid_i = 1'b1; elem_i = t_el[k];
      end else elem_valid_i = 1'b0;
      if (t_stall > 0 && nc_in_valid_o && sd <= t_stall) begin
        if (sd == 0) begin
          cap_ops = nc_operands_o; cap_tag = nc_tag_o;
        end else begin
          chk("stall_ops0", nc_operands_o[0], cap_ops[0]);
          chk("stall_ops1", nc_operands_o[1], cap_ops[1]);
          chk("stall_tag", {31'd0, nc_tag_o}, {31'd0, cap_tag});
        end
        stall = (sd < t_stall);
        sd++;
      end else stall = 1'b0;
      cons = elem_valid_i && elem_ready_o;
      @(posedge clk); r_lat++;
      if (cons) k++;
      @(negedge clk); g++;
    end
    elem_valid_i = 1'b0; stall = 1'b0;
    chk("done_seen", {31'd0, res_valid_o}, 32'd1);
    r_res = res_o; r_err = res_err_o;
    for (int h = 0; h < t_hold; h++) begin
      start_i = 1'b1; len_i = LW'(2); mode_i = MAX;
      @(posedge clk); @(negedge clk);
      chk("hold_valid", {31'd0, res_valid_o}, 32'd1);
      chk("hold_res", res_o, r_res);
    end
    start_i = 1'b0; res_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  typedef struct {
    roundmode_e  m;
    int          n;
    logic [31:0] e[4];
    logic [31:0] r;
  } vec_t;

  vec_t vecs[7];

  task automatic set_vec(input int i, input roundmode_e m, input int n, input logic [31:0] e0,
                         input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
                         input logic [31:0] r);
    vecs[i].m = m; vecs[i].n = n; vecs[i].r = r;
    vecs[i].e[0] = e0; vecs[i].e[1] = e1; vecs[i].e[2] = e2; vecs[i].e[3] = e3;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, g;
    logic cons, seen;

    set_vec(0, MIN, 3, 32'h40000000, 32'hC0000000, 32'h00000000, 32'h0, 32'hC0000000);
    set_vec(1, MAX, 2, 32'h40000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000);
    set_vec(2, MAX, 2, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h80000000);
    set_vec(3, MAX, 1, 32'h3F000000, 32'h0, 32'h0, 32'h0, 32'h3F000000);
    set_vec(4, MIN, 2, 32'h80000000, 32'h12345678, 32'h0, 32'h0, 32'h12345678);
    set_vec(5, MAX, 4, 32'hC0000000, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 32'h00000001);
    set_vec(6, MIN, 4, 32'h7FFFFFFF, 32'h00000000, 32'h80000001, 32'hFFFFFFFF, 32'h80000001);

    #12;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_valids", {28'd0, res_valid_o, nc_in_valid_o, elem_ready_o, nc_out_ready_o}, 32'd0);
    chk("rst_ops", nc_operands_o[0] | nc_operands_o[1], 32'd0);
    chk("rst_res", {res_o[30:0], res_err_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // illegal lengths must not leave IDLE
    @(negedge clk); start_i = 1'b1; len_i = '0;
    @(negedge clk); chk("len0_ignored", {31'd0, busy_o}, 32'd0);
    len_i = LW'(MAXL + 1);
    @(negedge clk); chk("len_over_ignored", {31'd0, busy_o}, 32'd0);
    start_i = 1'b0;

    t_gap = 0; t_stall = 0; t_hold = 0; use_lat = 1'b0;
    for (int i = 0; i < 7; i++) begin
      t_mode = vecs[i].m; t_len = vecs[i].n;
      for (int j = 0; j < 4; j++) t_el[j] = vecs[i].e[j];
      run_red();
      chk($sformatf("vec%0d_res", i), r_res, vecs[i].r);
      chk($sformatf("vec%0d_err", i), {31'd0, r_err}, 32'd0);
      chk($sformatf("vec%0d_lat", i), r_lat, 2 * vecs[i].n);
      chk($sformatf("vec%0d_idle", i), {31'd0, busy_o}, 32'd0);
      if (vecs[i].n == 1) chk("len1_no_issue", iv_cnt, 0);
    end

    // request held under downstream backpressure
    t_mode = MIN; t_len = 2; t_el[0] = 32'h5; t_el[1] = 32'hFFFFFFF0; t_stall = 3;
    run_red();
    chk("stall_res", r_res, 32'hFFFFFFF0);
    t_stall = 0;

    // wrong tag on the second response sets the sticky error, next start clears it
    t_mode = MAX; t_len = 3; t_el[0] = 32'h1; t_el[1] = 32'h2; t_el[2] = 32'h3; flip_en = 1'b1;
    run_red();
    chk("tagflip_res", r_res, 32'h3);
    chk("tagflip_err", {31'd0, r_err}, 32'd1);
    flip_en = 1'b0;
    run_red();
    chk("tag_ok_err", {31'd0, r_err}, 32'd0);

    // result held while consumer stalls; starts during DONE are ignored
    t_mode = MAX; t_len = 2; t_el[0] = 32'h10; t_el[1] = 32'h20; t_hold = 4;
    run_red();
    chk("hold_final", r_res, 32'h20);
    chk("hold_idle", {31'd0, busy_o}, 32'd0);
    t_hold = 0;

    // flush while waiting on a registered downstream response
    use_lat = 1'b1;
    @(negedge clk); start_i = 1'b1; mode_i = MIN; len_i = LW'(3);
    @(negedge clk); start_i = 1'b0;
    k = 0; g = 0;
    while (!nc_in_valid_o && g < 50) begin
      elem_valid_i = 1'b1; elem_i = 32'h100 + k;
      cons = elem_ready_o;
      @(posedge clk); if (cons) k++;
      @(negedge clk); g++;
    end
    elem_valid_i = 1'b0;
    chk("flush_in_issue", {31'd0, nc_in_valid_o}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("flush_wait_state", {30'd0, nc_in_valid_o, nc_out_ready_o}, 32'd1);
    chk("flush_rsp_pending", {31'd0, nc_out_valid_i}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk); @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_valids", {29'd0, res_valid_o, nc_in_valid_o, elem_ready_o}, 32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk); seen |= res_valid_o | busy_o;
    end
    chk("flush_quiet", {31'd0, seen}, 32'd0);

    // randomized reductions against the reference model
    t_gap = 30;
    for (int i = 0; i < 40; i++) begin
      use_lat = 1'($urandom_range(1));
      t_mode  = $urandom_range(1) ? MAX : MIN;
      t_len   = $urandom_range(MAXL, 1);
      for (int j = 0; j < t_len; j++)
        t_el[j] = ($urandom_range(3) == 0) ? NAR : $urandom;
      run_red();
      chk($sformatf("rand%0d_res", i), r_res, model());
      chk($sformatf("rand%0d_err", i), {31'd0, r_err}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
